mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequential shift-add controller for a 32-bit unsigned multiply, 32x32 -> 64 bits.
- Owns no adder. Each iteration it drives operands into an external combinational 32-bit ripple/carry-select adder and consumes that adder's sum and carry-out.
- Sits in the execute stage beside the ALU. It time-shares the adder in place of a dedicated array multiplier.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 32, operand width. It must equal the external adder width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- op_a  input  WIDTH  multiplicand
- op_b  input  WIDTH  multiplier
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- prod_hi  output  WIDTH  product bits [63:32]
- prod_lo  output  WIDTH  product bits [31:0]
- add_a  output  WIDTH  to adder input a
- add_b  output  WIDTH  to adder input b
- add_ci  output  1  to adder carry-in
- add_s  input  WIDTH  from adder sum
- add_co  input  1  from adder carry-out

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: state=IDLE; hi, lo, mcand and cnt all 0. Hence out_valid=0, prod_hi=prod_lo=0 and in_ready=1.
- Reset has priority over everything. Asserting rst mid-BUSY or in DONE aborts the operation and discards the result, with no out_valid pulse.
- States:
  - IDLE: in_ready=1. On in_valid=1 at an edge, load hi=0, lo=op_b, mcand=op_a, cnt=0, and go to BUSY.
  - BUSY: in_ready=0. Each edge does one iteration: {hi,lo} <= {add_co, add_s, lo[WIDTH-1:1]} and cnt <= cnt+1. When cnt==WIDTH-1 at the edge, go to DONE.
  - DONE: out_valid=1, in_ready=0. When out_valid&out_ready at an edge, go to IDLE.
- Adder drive:
  - In BUSY: add_a=hi, add_b = lo[0] ? mcand : 0, add_ci=0.
  - In IDLE and DONE: add_a=0, add_b=0, add_ci=0, so the adder output is quiet.
- Outputs: prod_hi=hi and prod_lo=lo at all times, with out_valid qualifying them. In DONE, prod_hi/prod_lo stay stable while out_ready=0, for any number of cycles.
- Latency: exactly WIDTH (32) edges from the accepting edge to the first cycle with out_valid=1.
- Throughput: one product per 34 cycles minimum. There is no same-cycle restart, because in_ready is low in DONE even when out_ready=1.
- in_valid in BUSY or DONE is ignored, and op_a/op_b are not sampled then. Operands are captured only at the accepting edge, so later changes have no effect.
- cnt never wraps. It is cleared at accept and stops advancing outside BUSY.
- The counter is unsigned: WIDTH-1 = 31 fits in CNT_W bits.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- With the macro defined: if op_a==0 or op_b==0 at the accepting edge, the controller loads hi=0 and lo=0 and goes straight from IDLE to DONE. out_valid is then high in the cycle after the accept (latency 1), and the adder is never driven for that request.
- With the macro undefined: zero operands take the full 32-iteration path. The result is still 0 and latency is 32.
- Non-zero operands behave identically in both builds.

Test Plan:
- Basic multiply: op_a=3, op_b=5, out_ready=1 -> out_valid rises 32 edges after accept; prod_hi=0x00000000, prod_lo=0x0000000F; in_ready=1 the cycle after the handshake.
- Max operands: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001. Also 0x80000000*2 -> prod_hi=0x00000001, prod_lo=0x00000000.
- Back-pressure plus busy-ignore:
  - op_a=0x12345678, op_b=0x9ABCDEF0. Re-pulse in_valid with different operands during BUSY -> no effect.
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and product held stable. Expected prod_hi=0x0B00EA4E, prod_lo=0x242D2080.
  - Single handshake then IDLE.
- Reset mid-operation: assert rst 10 cycles after accepting 7*9 -> next cycle state IDLE, out_valid=0, prod=0, in_ready=1. A new request 6*7 -> prod_lo=0x0000002A after 32 edges.
- Adder quiet: in IDLE and DONE, add_a=add_b=0 and add_ci=0 on every cycle. In BUSY with lo[0]=0, add_b=0.
- Zero skip: op_a=0, op_b=0x55 -> with MUL_ZERO_SKIP_EN, out_valid at latency 1 with product 0. Without the macro, latency 32 with product 0.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Shift-add 32x32->64 unsigned multiply sequencer driving a shared external adder.
// Optional MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero product.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             last;
    logic             zero_op;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (op_a == '0) || (op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign busy = (state == S_BUSY);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        hi    <= '0;
                        mcand <= op_a;
                        cnt   <= '0;
                        if (zero_op) begin
                            lo    <= '0;
                            state <= S_DONE;
                        end else begin
                            lo    <= op_b;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Adder carry becomes the new top bit; multiplier bits shift out of lo.
                    {hi, lo} <= {add_co, add_s, lo[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign prod_hi   = hi;
    assign prod_lo   = lo;

    // Adder inputs held at zero outside BUSY so the shared adder stays quiet.
    assign add_a  = busy ? hi : '0;
    assign add_b  = (busy && lo[0]) ? mcand : '0;
    assign add_ci = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized bench for mul_seq_ctrl against an arithmetic product model.
// Provides the external adder; honours MUL_ZERO_SKIP_EN.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ci;
    logic [31:0] add_s;
    logic        add_co;

    int checks = 0;
    int failures = 0;

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod_hi(prod_hi), .prod_lo(prod_lo),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co)
    );

    always #5 clk = ~clk;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {add_a, add_b, 31'd0, add_ci}, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit noise);
        logic [63:0] exp_p;
        logic [63:0] part;
        bit          skip;
        int          exp_lat;
        int          k;
        exp_p = {32'd0, a} * {32'd0, b};
`ifdef MUL_ZERO_SKIP_EN
        skip = (a == 0) || (b == 0);
`else
        skip = 1'b0;
`endif
        exp_lat = skip ? 0 : 32;
        chk("idle_rdy", {63'd0, in_ready}, 64'd1);
        chk_quiet("idle_quiet");
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        k = 0;
        while (!out_valid && k < 40) begin
            if (k < 32) begin
                // hi after k iterations is the partial product of the low k multiplier bits
                part = {32'd0, a} * ({32'd0, b} & ((64'd1 << k) - 64'd1));
                chk("busy_add_a", {32'd0, add_a}, part >> k);
                chk("busy_add_b", {32'd0, add_b}, b[k] ? {32'd0, a} : 64'd0);
                chk("busy_ci", {63'd0, add_ci}, 64'd0);
                chk("busy_rdy", {63'd0, in_ready}, 64'd0);
            end
            @(negedge clk);
            k++;
            in_valid = noise && (k == 5);
            op_a = $urandom;
            op_b = $urandom;
        end
        in_valid = 1'b0;
        chk("latency", 64'(k), 64'(exp_lat));
        chk("product", {prod_hi, prod_lo}, exp_p);
        chk_quiet("done_quiet");
        chk("done_rdy", {63'd0, in_ready}, 64'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = noise;
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_prod", {prod_hi, prod_lo}, exp_p);
            chk_quiet("hold_quiet");
        end
        out_ready = 1'b1;
        in_valid  = noise;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rdy", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);
        chk_quiet("rst_quiet");

        run_op(32'd3, 32'd5, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(32'h80000000, 32'd2, 1, 1'b0);
        run_op(32'h12345678, 32'h9ABCDEF0, 5, 1'b1);
        run_op(32'd0, 32'h55, 2, 1'b0);
        run_op(32'h55, 32'd0, 0, 1'b1);

        in_valid = 1'b1;
        op_a = 32'd7;
        op_b = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        chk("abort_rdy", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_pulse", 64'(seen), 64'd0);
        run_op(32'd6, 32'd7, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: rb = '0;
                2: ra = 32'hFFFFFFFF;
                3: rb = 32'd1 << $urandom_range(0, 31);
                default: ;
            endcase
            run_op(ra, rb, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
